decoder_dualrail_acc: RTL and testbench
=======================================

# decoder_dualrail_acc

Parametrised dual-rail to one-hot decoder with accumulation. It generalises the fixed 2-bit AND-based decoder to SIZE input bits. Rail pulses for a word may arrive spread over several clock cycles; the block collects them and checks that the word is complete and consistent. It then emits a registered one-hot code with a valid strobe and flags conflicting or stale words. It sits between dual-rail pulse sources and single-rail one-hot consumers in the clocked pulse-logic datapath.

## Interface
- SIZE, 2, number of dual-rail input bits; out width is 2**SIZE; legal range 1..6
- TIMEOUT, 15, cycles a partial word may wait before being discarded; 0 disables the timeout
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in  input  [SIZE-1:0][1:0]  dual-rail pulses per bit
  - in[i][0] = positive rail (bit i = 1)
  - in[i][1] = negative rail (bit i = 0)
- en  input  1  when low, in is ignored and all state is held
- out  output  2**SIZE  one-hot decoded word; out[k] means value k, bit 0 is the LSB; all-zero when out_valid is low
- out_valid  output  1  one-cycle strobe qualifying out
- err_conflict  output  1  one-cycle strobe: a bit saw both rails
- err_timeout  output  1  one-cycle strobe: a partial word expired
- busy  output  1  accumulator holds at least one rail

## Operation
- State
  - acc_pos[SIZE-1:0] and acc_neg[SIZE-1:0] hold the rails seen so far.
  - tmr is the timeout counter, $clog2(TIMEOUT+1) bits wide; with TIMEOUT=0 it is tied to 0.
- Each rising edge with rst_n=1 and en=1:
  - nxt_pos = acc_pos | in[*][0]
  - nxt_neg = acc_neg | in[*][1]
  - conflict = |(nxt_pos & nxt_neg)
  - complete = &(nxt_pos ^ nxt_neg)
- Priority, evaluated on the nxt_* values:
  1. conflict: err_conflict<=1; clear acc and tmr; out stays 0.
  2. complete: out <= 1 << value(nxt_pos); out_valid<=1; clear acc and tmr.
  3. TIMEOUT!=0, (nxt_pos|nxt_neg)!=0 and tmr==TIMEOUT-1: err_timeout<=1; clear acc and tmr.
  4. Otherwise:
     - acc <= nxt.
     - tmr increments if nxt is non-zero; it stays 0 if nxt is zero.
- Rails sampled on the edge that completes, conflicts or times out belong to that word. They are consumed and never carried into the next word.
- A word that completes in a single cycle (all rails in one cycle) is decoded directly; the accumulator was empty before and stays empty after.
- A repeated pulse on an already-seen rail is harmless: the OR is idempotent.
- en=0:
  - acc and tmr hold.
  - out, out_valid, err_conflict and err_timeout go to 0 on that edge.
- busy = |(acc_pos|acc_neg), combinational from registers.
- Reset (rst_n=0 at an edge):
  - acc, tmr, out, out_valid, err_conflict and err_timeout all go to 0, so busy=0.
  - Reset overrides en and in; a mid-word reset discards the partial word without any error strobe.

## Timing
- Latency: the strobe (out_valid or an error flag) is visible in the cycle after the edge that samples the final rail, i.e. 1 cycle registered.
- All strobes are exactly 1 cycle wide unless the next edge produces another event.
- Back-to-back words are supported at full rate, one decode per cycle.
- Outputs are mutually exclusive: at most one of out_valid, err_conflict and err_timeout is high in any cycle.
- Timeout: a word whose first rail is sampled at edge e and is still incomplete is discarded at edge e+TIMEOUT-1. err_timeout is high after that edge.
- No combinational path from in to any output.

## Test plan
- SIZE=2, in={bit1 neg, bit0 pos} (in[1][1]=1, in[0][0]=1) in one cycle -> next cycle out=4'b0010, out_valid=1; busy never asserts.
- SIZE=3:
  - bit0 pos at cycle 0, bit2 pos at cycle 2, bit1 neg at cycle 5 -> busy=1 in cycles 1..5.
  - After edge 5: out=8'b0010_0000 (value 5), out_valid=1 for 1 cycle, busy=0.
- SIZE=2, bit0 pos at cycle 0, then bit0 neg at cycle 1 -> err_conflict=1 in cycle 2, out=0, busy=0; a following clean word decodes normally.
- SIZE=2, TIMEOUT=4, only bit1 pos at cycle 0 and nothing further -> err_timeout=1 in cycle 4, busy=0.
- SIZE=2, TIMEOUT=0, the same single rail -> busy stays 1 indefinitely and no error is raised.
- Partial word pending, en=0 for 10 cycles -> no timeout and acc held. Then en=1 with the remaining rail -> correct one-hot decode.
- Partial word pending, rst_n=0 for one edge -> all outputs 0 and busy=0. Supplying the remaining rail afterwards leaves the word incomplete: no out_valid.

Source files
------------

// File: rtl/decoder_dualrail_acc.sv
// Dual-rail to one-hot decoder that accumulates rail pulses spread over several
// cycles, emitting a registered one-hot word or a conflict/timeout strobe.
module decoder_dualrail_acc #(
  parameter int unsigned SIZE    = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SIZE-1:0][1:0]      in_i,
  input  logic                      en_i,
  output logic [(2**SIZE)-1:0]      out_o,
  output logic                      out_valid_o,
  output logic                      err_conflict_o,
  output logic                      err_timeout_o,
  output logic                      busy_o
);

  localparam int unsigned OUT_W    = 2 ** SIZE;
  localparam int unsigned TMR_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TMR_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [SIZE-1:0]  acc_pos_q, acc_pos_d;
  logic [SIZE-1:0]  acc_neg_q, acc_neg_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             conf_q, conf_d;
  logic             tmo_q, tmo_d;

  logic [SIZE-1:0]  rail_pos, rail_neg;
  logic [SIZE-1:0]  nxt_pos, nxt_neg;
  logic             conflict, complete, any_rail;

  // Split the dual-rail bus and merge it with the rails already collected.
  always_comb begin
    rail_pos = '0;
    rail_neg = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      rail_pos[i] = in_i[i][0];
      rail_neg[i] = in_i[i][1];
    end
    nxt_pos  = acc_pos_q | rail_pos;
    nxt_neg  = acc_neg_q | rail_neg;
    conflict = |(nxt_pos & nxt_neg);
    complete = &(nxt_pos ^ nxt_neg);
    any_rail = |(nxt_pos | nxt_neg);
  end

  // Next state: conflict beats completion, completion beats timeout.
  always_comb begin
    acc_pos_d = acc_pos_q;
    acc_neg_d = acc_neg_q;
    tmr_d     = tmr_q;
    out_d     = '0;
    valid_d   = 1'b0;
    conf_d    = 1'b0;
    tmo_d     = 1'b0;
    if (en_i) begin
      if (conflict) begin
        conf_d    = 1'b1;
        acc_pos_d = '0;
        acc_neg_d = '0;
        tmr_d     = '0;
      end else if (complete) begin
        out_d     = OUT_W'(1) << nxt_pos;
        valid_d   = 1'b1;
        acc_pos_d = '0;
        acc_neg_d = '0;
        tmr_d     = '0;
      end else if ((TIMEOUT != 0) && any_rail && (tmr_q == TMR_W'(TMR_LAST))) begin
        tmo_d     = 1'b1;
        acc_pos_d = '0;
        acc_neg_d = '0;
        tmr_d     = '0;
      end else begin
        acc_pos_d = nxt_pos;
        acc_neg_d = nxt_neg;
        tmr_d     = any_rail ? tmr_q + TMR_W'(1) : '0;
      end
    end
    if (TIMEOUT == 0) begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_pos_q <= '0;
      acc_neg_q <= '0;
      tmr_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      conf_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      acc_pos_q <= acc_pos_d;
      acc_neg_q <= acc_neg_d;
      tmr_q     <= tmr_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      conf_q    <= conf_d;
      tmo_q     <= tmo_d;
    end
  end

  assign out_o          = out_q;
  assign out_valid_o    = valid_q;
  assign err_conflict_o = conf_q;
  assign err_timeout_o  = tmo_q;
  assign busy_o         = |(acc_pos_q | acc_neg_q);

endmodule

// File: tb/tb_decoder_dualrail_acc.sv
// Scoreboard bench for decoder_dualrail_acc: three instances (SIZE=2/TIMEOUT=4,
// SIZE=3/TIMEOUT=15, SIZE=2/TIMEOUT=0) driven cycle by cycle.
module tb_decoder_dualrail_acc;

  typedef struct packed {
    logic [5:0] in;
    logic       en;
    logic       rst_n;
  } stim_t;

  typedef struct packed {
    logic [7:0] out;
    logic       valid;
    logic       conf;
    logic       tmo;
    logic       busy;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam int DUT_A = 0;
  localparam int DUT_B = 1;
  localparam int DUT_Z = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, en_a, v_a, c_a, t_a, b_a;
  logic [1:0][1:0] in_a;
  logic [3:0]      out_a;
  logic            rst_b, en_b, v_b, c_b, t_b, b_b;
  logic [2:0][1:0] in_b;
  logic [7:0]      out_b;
  logic            rst_z, en_z, v_z, c_z, t_z, b_z;
  logic [1:0][1:0] in_z;
  logic [3:0]      out_z;

  decoder_dualrail_acc #(.SIZE(2), .TIMEOUT(4)) u_a (
    .clk(clk), .rst_n(rst_a), .in_i(in_a), .en_i(en_a), .out_o(out_a),
    .out_valid_o(v_a), .err_conflict_o(c_a), .err_timeout_o(t_a), .busy_o(b_a));

  decoder_dualrail_acc #(.SIZE(3), .TIMEOUT(15)) u_b (
    .clk(clk), .rst_n(rst_b), .in_i(in_b), .en_i(en_b), .out_o(out_b),
    .out_valid_o(v_b), .err_conflict_o(c_b), .err_timeout_o(t_b), .busy_o(b_b));

  decoder_dualrail_acc #(.SIZE(2), .TIMEOUT(0)) u_z (
    .clk(clk), .rst_n(rst_z), .in_i(in_z), .en_i(en_z), .out_o(out_z),
    .out_valid_o(v_z), .err_conflict_o(c_z), .err_timeout_o(t_z), .busy_o(b_z));

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  function automatic exp_t mk_e(input logic [7:0] o, input logic v, input logic c,
                                input logic t, input logic b);
    mk_e = '{out: o, valid: v, conf: c, tmo: t, busy: b};
  endfunction

  function automatic stim_t mk_s(input logic [5:0] i, input logic e = 1'b1,
                                 input logic r = 1'b1);
    mk_s = '{in: i, en: e, rst_n: r};
  endfunction

  function automatic exp_t obs_of(input int d);
    case (d)
      DUT_A:   obs_of = mk_e(8'(out_a), v_a, c_a, t_a, b_a);
      DUT_B:   obs_of = mk_e(out_b, v_b, c_b, t_b, b_b);
      default: obs_of = mk_e(8'(out_z), v_z, c_z, t_z, b_z);
    endcase
  endfunction

  task automatic apply(input int d, input stim_t s);
    case (d)
      DUT_A:   begin in_a = s.in[3:0]; en_a = s.en; rst_a = s.rst_n; end
      DUT_B:   begin in_b = s.in;      en_b = s.en; rst_b = s.rst_n; end
      default: begin in_z = s.in[3:0]; en_z = s.en; rst_z = s.rst_n; end
    endcase
  endtask

  task automatic test_reset();
    exp_t got;
    for (int d = 0; d < 3; d++) begin
      got = obs_of(d);
      n_checks++;
      if (got !== mk_e(8'h00, 1'b0, 1'b0, 1'b0, 1'b0))
        $display("FAIL reset dut%0d: got %h want 000", d, got);
      else n_pass++;
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_z = 1'b1;
    en_a = 1'b1;  en_b = 1'b1;  en_z = 1'b1;
  endtask

  task automatic test_single_cycle();
    vec_t vq[$];
    exp_t got, want;
    vq.push_back('{mk_s(6'b0), mk_e(8'h00, 0, 0, 0, 0)});
    vq.push_back('{mk_s(6'b1001), mk_e(8'b0010, 1, 0, 0, 0)});
    vq.push_back('{mk_s(6'b0), mk_e(8'h00, 0, 0, 0, 0)});
    foreach (vq[k]) begin
      apply(DUT_A, vq[k].s);
      sb.push_back(vq[k].e);
      @(posedge clk); #1;
      got = obs_of(DUT_A); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL single_cycle[%0d]: got %h want %h", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_accumulate();
    vec_t vq[$];
    exp_t got, want;
    vq.push_back('{mk_s(6'b00_00_01), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),        mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b01_00_00), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b00_00_01), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),        mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b00_10_00), mk_e(8'b0010_0000, 1, 0, 0, 0)});
    vq.push_back('{mk_s(6'b0),        mk_e(8'h00, 0, 0, 0, 0)});
    foreach (vq[k]) begin
      apply(DUT_B, vq[k].s);
      sb.push_back(vq[k].e);
      @(posedge clk); #1;
      got = obs_of(DUT_B); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL accumulate[%0d]: got %h want %h", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] w;
    exp_t got, want;
    for (int v = 0; v < 8; v++) begin
      w = '0;
      for (int i = 0; i < 3; i++) w[2*i +: 2] = v[i] ? 2'b01 : 2'b10;
      apply(DUT_B, mk_s(w));
      sb.push_back(mk_e(8'(1 << v), 1, 0, 0, 0));
      @(posedge clk); #1;
      got = obs_of(DUT_B); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL back_to_back[%0d]: got %h want %h", v, got, want);
      else n_pass++;
    end
    apply(DUT_B, mk_s(6'b0));
    sb.push_back(mk_e(8'h00, 0, 0, 0, 0));
    @(posedge clk); #1;
    got = obs_of(DUT_B); want = sb.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL back_to_back_idle: got %h want %h", got, want);
    else n_pass++;
  endtask

  task automatic test_conflict();
    vec_t vq[$];
    exp_t got, want;
    vq.push_back('{mk_s(6'b0001), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0010), mk_e(8'h00, 0, 1, 0, 0)});
    vq.push_back('{mk_s(6'b0110), mk_e(8'b0100, 1, 0, 0, 0)});
    vq.push_back('{mk_s(6'b0011), mk_e(8'h00, 0, 1, 0, 0)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 0, 0)});
    foreach (vq[k]) begin
      apply(DUT_A, vq[k].s);
      sb.push_back(vq[k].e);
      @(posedge clk); #1;
      got = obs_of(DUT_A); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL conflict[%0d]: got %h want %h", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    vec_t vq[$];
    exp_t got, want;
    // Single rail expires on the fourth edge of the word.
    vq.push_back('{mk_s(6'b0100), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 1, 0)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 0, 0)});
    // Completing on the expiry edge decodes instead of timing out.
    vq.push_back('{mk_s(6'b0001), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b1000), mk_e(8'b0010, 1, 0, 0, 0)});
    foreach (vq[k]) begin
      apply(DUT_A, vq[k].s);
      sb.push_back(vq[k].e);
      @(posedge clk); #1;
      got = obs_of(DUT_A); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL timeout[%0d]: got %h want %h", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_no_timeout();
    exp_t got, want;
    for (int k = 0; k < 20; k++) begin
      apply(DUT_Z, mk_s(k == 0 ? 6'b0100 : 6'b0));
      sb.push_back(mk_e(8'h00, 0, 0, 0, 1));
      @(posedge clk); #1;
      got = obs_of(DUT_Z); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL no_timeout[%0d]: got %h want %h", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_en_hold();
    vec_t vq[$];
    exp_t got, want;
    vq.push_back('{mk_s(6'b0010), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 0, 1)});
    for (int k = 0; k < 10; k++)
      vq.push_back('{mk_s(6'b1111, 1'b0), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0100), mk_e(8'b0100, 1, 0, 0, 0)});
    vq.push_back('{mk_s(6'b1001, 1'b0), mk_e(8'h00, 0, 0, 0, 0)});
    foreach (vq[k]) begin
      apply(DUT_A, vq[k].s);
      sb.push_back(vq[k].e);
      @(posedge clk); #1;
      got = obs_of(DUT_A); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL en_hold[%0d]: got %h want %h", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midword();
    vec_t vq[$];
    exp_t got, want;
    vq.push_back('{mk_s(6'b0001), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b1000, 1'b1, 1'b0), mk_e(8'h00, 0, 0, 0, 0)});
    vq.push_back('{mk_s(6'b1000), mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0),    mk_e(8'h00, 0, 0, 0, 1)});
    vq.push_back('{mk_s(6'b0, 1'b1, 1'b0), mk_e(8'h00, 0, 0, 0, 0)});
    foreach (vq[k]) begin
      apply(DUT_A, vq[k].s);
      sb.push_back(vq[k].e);
      @(posedge clk); #1;
      got = obs_of(DUT_A); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL reset_midword[%0d]: got %h want %h", k, got, want);
      else n_pass++;
    end
    rst_a = 1'b1;
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b0; in_a = '0;
    rst_b = 1'b0; en_b = 1'b0; in_b = '0;
    rst_z = 1'b0; en_z = 1'b0; in_z = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_cycle();
    test_accumulate();
    test_back_to_back();
    test_conflict();
    test_timeout();
    test_no_timeout();
    test_en_hold();
    test_reset_midword();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
